// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared definitions for the raster pixel source and its stream FIFO:
//   state_e    reader FSM encoding (IDLE, READ, DRAIN, DONE)
//   pix_tag_t  sideband carried alongside each pixel {col, sof, eol, eof}
//   DEPTH      stream FIFO depth; CNT_W is the width of its occupancy count
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int DEPTH     = 2;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  // Column field is sized for the widest supported line (65536 pixels);
  // each stage narrows it to its own column width.
  localparam int TAG_COL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_COL_W-1:0] col;
    logic                 sof;
    logic                 eol;
    logic                 eof;
  } pix_tag_t;

endpackage

// File: rtl/image_stream_reader_if.sv
// ---------------------------------------------------------------------------
// image_stream_reader_if
// Bundles the reader's control, frame-buffer read and pixel stream signals.
//   master : reader side (drives busy/done, RAM read strobe/address, stream)
//   slave  : environment side (drives start, RAM data, pix_ready)
// ---------------------------------------------------------------------------
interface image_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19,
  parameter int COL_W      = 10
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic [COL_W-1:0]      col_addr;
  logic                  sof;
  logic                  eol;
  logic                  eof;

  modport master (
    input  start, mem_rd_data, pix_ready,
    output busy, done, mem_rd_en, mem_rd_addr,
           pix_valid, pixel_out, col_addr, sof, eol, eof
  );

  modport slave (
    output start, mem_rd_data, pix_ready,
    input  busy, done, mem_rd_en, mem_rd_addr,
           pix_valid, pixel_out, col_addr, sof, eol, eof
  );

endinterface

// File: rtl/stream_skid_fifo.sv
// ---------------------------------------------------------------------------
// stream_skid_fifo
// DEPTH-entry FIFO holding a data word plus a pix_tag_t per entry.
//   clk, rst        clock; asynchronous active-low reset (empties the FIFO)
//   push_i          write push_data_i/push_tag_i (dropped if full without pop)
//   pop_i           retire the head entry (ignored when empty)
//   head_data_o     data at the head (meaningful only when count_o != 0)
//   head_tag_o      tag at the head
//   count_o         current occupancy
// Push and pop in the same cycle leave the count unchanged, including from full.
// ---------------------------------------------------------------------------
module stream_skid_fifo
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  pix_tag_t              push_tag_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output pix_tag_t              head_tag_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  pix_tag_t              tag_q  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Storage carries no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= push_data_i;
      tag_q[wr_ptr_q]  <= push_tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_tag_o  = tag_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/image_stream_reader.sv
// ---------------------------------------------------------------------------
// image_stream_reader
// Streams one raster frame from a synchronous frame-buffer RAM on start.
//   clk, rst   clock; asynchronous active-low reset (aborts any frame)
//   bus        image_stream_reader_if.master:
//                start/busy/done              frame control
//                mem_rd_en/mem_rd_addr/_data  RAM read port (1-cycle latency)
//                pix_valid/pix_ready          stream handshake
//                pixel_out/col_addr/sof/eol/eof  beat payload
// Reads are issued only while the FIFO plus the in-flight read leave room,
// so backpressure never drops or duplicates a pixel.
// ---------------------------------------------------------------------------
module image_stream_reader
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = $clog2(BASE_ADDR + IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic clk,
  input  logic rst,
  image_stream_reader_if.master bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_READ  = ST_READ;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]            state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q;
  pix_tag_t              inflight_tag_q;
  logic                  busy_q, done_q;

  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] head_data;
  pix_tag_t              head_tag;
  logic [CNT_W:0]        occupancy;
  pix_tag_t              issue_tag;
  logic                  pix_valid;
  logic                  pop;
  logic                  rd_en;
  logic                  last_issue;

  assign pix_valid = (fifo_count != '0);
  assign pop       = pix_valid && bus.pix_ready;

  // Slots claimed after this cycle: stored + in flight - retiring now.
  // pop implies fifo_count >= 1, so this never underflows.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign rd_en     = (state_q == S_READ) && (occupancy < (CNT_W+1)'(DEPTH));

  assign last_issue = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    issue_tag     = '0;
    issue_tag.col = TAG_COL_W'(col_q);
    issue_tag.sof = (col_q == '0) && (row_q == '0);
    issue_tag.eol = (col_q == COL_LAST);
    issue_tag.eof = last_issue;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          col_d   = '0;
          row_d   = '0;
          addr_d  = ADDR_BASE;
        end
      end
      S_READ: begin
        if (rd_en) begin
          addr_d = addr_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            // Row stays put after the final pixel so it never wraps.
            if (!last_issue) row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_tag.eof) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      addr_q         <= addr_d;
      inflight_q     <= rd_en;
      inflight_tag_q <= issue_tag;
      busy_q         <= (state_d == S_READ) || (state_d == S_DRAIN);
      done_q         <= (state_d == S_DONE);
    end
  end

  // RAM data lands one cycle after the strobe; pair it with the tag captured then.
  stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.mem_rd_data),
    .push_tag_i  (inflight_tag_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_tag_o  (head_tag),
    .count_o     (fifo_count)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = addr_q;
  assign bus.pix_valid   = pix_valid;
  // Payload is forced to zero while the stream is idle.
  assign bus.pixel_out   = pix_valid ? head_data : '0;
  assign bus.col_addr    = pix_valid ? COL_W'(head_tag.col) : '0;
  assign bus.sof         = pix_valid && head_tag.sof;
  assign bus.eol         = pix_valid && head_tag.eol;
  assign bus.eof         = pix_valid && head_tag.eof;

endmodule
